// File: rtl/laser_controller.sv
// laser_controller: frame-paced laser beam sequencer feeding the laser render layer.
// A fire request starts a beam in the player's quadrant. The beam extends, holds at
// full length and retracts. A cooldown period follows before the next fire is accepted.
// Optional build macro LASER_AUTOFIRE_EN: in IDLE the fire_req level fires, instead of
// only its rising edge.
module laser_controller #(
   parameter int STEP_FRAMES     = 2,
   parameter int HOLD_FRAMES     = 8,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int R_MAX           = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       fire_req,
   input  logic       abort,
   input  logic [1:0] player_quadrant,
   output logic       laser_active,
   output logic [3:0] laser_r,
   output logic [1:0] laser_quadrant,
   output logic       busy,
   output logic       hit_strobe
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter sized for the largest frame count. It only counts to count-1 before clearing.
   localparam int CNT_MAX = imax(imax(STEP_FRAMES, HOLD_FRAMES), imax(COOLDOWN_FRAMES, R_MAX));
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_FRAMES - 1);
   localparam logic [3:0]    R_FULL    = 4'(R_MAX);

   typedef enum logic [2:0] {IDLE, EXTEND, HOLD, RETRACT, COOLDOWN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    r_n;
   logic          act_n, hit_n, busy_n;
   logic [1:0]    quad_n;
   logic          fire_prev;
   logic          fire_edge, fire_go;

   assign fire_edge = fire_req & ~fire_prev;

`ifdef LASER_AUTOFIRE_EN
   assign fire_go = fire_req;
`else
   assign fire_go = fire_edge;
`endif

   // Register state, datapath and outputs. fire_prev resets high so a held button does not fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         laser_active   <= 1'b0;
         laser_r        <= 4'd0;
         laser_quadrant <= 2'd0;
         busy           <= 1'b0;
         hit_strobe     <= 1'b0;
         fire_prev      <= 1'b1;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         laser_active   <= act_n;
         laser_r        <= r_n;
         laser_quadrant <= quad_n;
         busy           <= busy_n;
         hit_strobe     <= hit_n;
         fire_prev      <= fire_req;
      end
   end

   // Next-state and next-output logic. abort overrides ticks in every beam state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      r_n     = laser_r;
      act_n   = laser_active;
      quad_n  = laser_quadrant;
      hit_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (fire_go && !abort) begin
               state_n = EXTEND;
               cnt_n   = '0;
               act_n   = 1'b1;
               r_n     = 4'd0;
               quad_n  = player_quadrant;
            end
         end
         EXTEND: begin
            if (abort) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
               act_n   = 1'b0;
               r_n     = 4'd0;
            end else if (frame_tick) begin
               hit_n = 1'b1;
               if (cnt == STEP_LAST) begin
                  cnt_n = '0;
                  r_n   = laser_r + 4'd1;
                  if (r_n == R_FULL) state_n = HOLD;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (abort) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
               act_n   = 1'b0;
               r_n     = 4'd0;
            end else if (frame_tick) begin
               hit_n = 1'b1;
               if (cnt == HOLD_LAST) begin
                  state_n = RETRACT;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         RETRACT: begin
            if (abort) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
               act_n   = 1'b0;
               r_n     = 4'd0;
            end else if (frame_tick) begin
               if (cnt == STEP_LAST) begin
                  cnt_n = '0;
                  r_n   = laser_r - 4'd1;
                  if (r_n == 4'd0) begin
                     state_n = COOLDOWN;
                     act_n   = 1'b0;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         COOLDOWN: begin
            if (frame_tick) begin
               if (cnt == COOL_LAST) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            act_n   = 1'b0;
            r_n     = 4'd0;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_laser_controller.sv
// Self-checking bench for laser_controller. It runs table-driven cycle vectors, then
// hand-written full-beam, abort and refire sequences, then a small-parameter instance.
module tb_laser_controller;

   logic       clk = 1'b0;
   logic       rst, frame_tick, fire_req, abort;
   logic [1:0] player_quadrant;
   logic       laser_active, busy, hit_strobe;
   logic [3:0] laser_r;
   logic [1:0] laser_quadrant;

   logic       rst2, tick2, fire2;
   logic       act2, busy2, hit2;
   logic [3:0] r2;
   logic [1:0] q2;

   int checks   = 0;
   int failures = 0;
   int hits     = 0;

   always #5 clk = ~clk;

   laser_controller dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire_req(fire_req), .abort(abort),
      .player_quadrant(player_quadrant), .laser_active(laser_active), .laser_r(laser_r),
      .laser_quadrant(laser_quadrant), .busy(busy), .hit_strobe(hit_strobe)
   );

   laser_controller #(.STEP_FRAMES(1), .R_MAX(1)) dut2 (
      .clk(clk), .rst(rst2), .frame_tick(tick2), .fire_req(fire2), .abort(1'b0),
      .player_quadrant(2'd3), .laser_active(act2), .laser_r(r2),
      .laser_quadrant(q2), .busy(busy2), .hit_strobe(hit2)
   );

   typedef struct {
      logic       rst, tick, fire, abrt;
      logic [1:0] quad;
      logic       act;
      logic [3:0] r;
      logic [1:0] q;
      logic       bsy, hit;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, pass the edge, sample 1 ns later, count hit strobes.
   task automatic cyc(input logic r, input logic t, input logic f, input logic a, input logic [1:0] qd);
      rst = r; frame_tick = t; fire_req = f; abort = a; player_quadrant = qd;
      @(posedge clk); #1;
      if (hit_strobe) hits++;
   endtask

   // n frames, each a tick cycle followed by a quiet cycle.
   task automatic run(input int n, input logic f, input logic [1:0] qd);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b1, f, 1'b0, qd);
         cyc(1'b0, 1'b0, f, 1'b0, qd);
      end
   endtask

   task automatic cyc2(input logic r, input logic t, input logic f);
      rst2 = r; tick2 = t; fire2 = f;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; fire_req = 1'b0; abort = 1'b0; player_quadrant = 2'd0;
      rst2 = 1'b1; tick2 = 1'b0; fire2 = 1'b0;

      //           rst  tick fire abrt quad  act  r     q     bsy  hit
      vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,2'd2, 1'b0,4'd0, 2'd0, 1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,2'd2, 1'b1,4'd0, 2'd2, 1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,2'd2, 1'b1,4'd0, 2'd2, 1'b1,1'b1};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,2'd2, 1'b1,4'd1, 2'd2, 1'b1,1'b1};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0,2'd2, 1'b1,4'd1, 2'd2, 1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b1,2'd2, 1'b0,4'd0, 2'd2, 1'b1,1'b0};

      for (int i = 0; i < 12; i++) begin
         cyc(vecs[i].rst, vecs[i].tick, vecs[i].fire, vecs[i].abrt, vecs[i].quad);
         chk($sformatf("vec%0d_active", i), laser_active, vecs[i].act);
         chk($sformatf("vec%0d_r", i), laser_r, vecs[i].r);
         chk($sformatf("vec%0d_quad", i), laser_quadrant, vecs[i].q);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
         chk($sformatf("vec%0d_hit", i), hit_strobe, vecs[i].hit);
      end

      // Full beam with default parameters; quadrant input changes mid-EXTEND.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      chk("full_start_active", laser_active, 1);
      hits = 0;
      run(10, 1'b0, 2'd1);
      run(19, 1'b0, 2'd3);
      chk("full_r_29ticks", laser_r, 14);
      run(1, 1'b0, 2'd3);
      chk("full_r_30ticks", laser_r, 15);
      chk("full_quad_extend", laser_quadrant, 1);
      run(7, 1'b0, 2'd3);
      chk("full_hold_r", laser_r, 15);
      run(1, 1'b0, 2'd3);
      chk("full_retract_start_r", laser_r, 15);
      run(29, 1'b0, 2'd3);
      chk("full_retract_r1", laser_r, 1);
      chk("full_retract_active", laser_active, 1);
      run(1, 1'b0, 2'd3);
      chk("full_retract_r0", laser_r, 0);
      chk("full_retract_inactive", laser_active, 0);
      chk("full_hits", hits, 38);
      chk("full_quad_end", laser_quadrant, 1);
      run(29, 1'b0, 2'd3);
      chk("full_cool_busy", busy, 1);
      run(1, 1'b0, 2'd3);
      chk("full_idle_busy", busy, 0);

      // Abort in HOLD, then presses during COOLDOWN are ignored.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      run(33, 1'b0, 2'd0);
      chk("abort_pre_r", laser_r, 15);
      hits = 0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      chk("abort_active", laser_active, 0);
      chk("abort_r", laser_r, 0);
      chk("abort_busy", busy, 1);
      chk("abort_hit", hit_strobe, 0);
      for (int i = 0; i < 29; i++) begin
         cyc(1'b0, 1'b1, (i % 2) == 1, 1'b0, 2'd0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      end
      chk("abort_cool_busy", busy, 1);
      chk("abort_cool_hits", hits, 0);
      chk("abort_cool_active", laser_active, 0);
      run(1, 1'b0, 2'd0);
      chk("abort_idle_busy", busy, 0);

      // Fire pressed and held during RETRACT.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      run(38, 1'b0, 2'd2);
      run(5, 1'b0, 2'd2);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
      chk("rt_press_r", laser_r, 13);
      run(25, 1'b1, 2'd2);
      chk("rt_end_active", laser_active, 0);
      chk("rt_end_busy", busy, 1);
      run(29, 1'b1, 2'd2);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
      chk("rt_cool_exit_busy", busy, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
`ifdef LASER_AUTOFIRE_EN
      chk("rt_refire_busy", busy, 1);
      chk("rt_refire_active", laser_active, 1);
`else
      chk("rt_refire_busy", busy, 0);
      run(2, 1'b1, 2'd2);
      chk("rt_no_refire_busy", busy, 0);
`endif

      // STEP_FRAMES=1, R_MAX=1 instance; synchronous reset mid-HOLD.
      cyc2(1'b1, 1'b0, 1'b0);
      cyc2(1'b0, 1'b0, 1'b0);
      cyc2(1'b0, 1'b0, 1'b1);
      chk("s1_fire_active", act2, 1);
      chk("s1_fire_r", r2, 0);
      chk("s1_fire_quad", q2, 3);
      cyc2(1'b0, 1'b1, 1'b1);
      chk("s1_tick1_r", r2, 1);
      chk("s1_tick1_hit", hit2, 1);
      cyc2(1'b0, 1'b0, 1'b1);
      chk("s1_quiet_hit", hit2, 0);
      cyc2(1'b0, 1'b1, 1'b1);
      chk("s1_hold_r", r2, 1);
      chk("s1_hold_hit", hit2, 1);
      cyc2(1'b1, 1'b0, 1'b1);
      chk("s1_rst_active", act2, 0);
      chk("s1_rst_r", r2, 0);
      chk("s1_rst_quad", q2, 0);
      chk("s1_rst_busy", busy2, 0);
      chk("s1_rst_hit", hit2, 0);
      cyc2(1'b0, 1'b0, 1'b1);
      chk("s1_held_no_fire", busy2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
